// File: rtl/mux_1b_2to1.sv
// ---------------------------------------------------------------------------
// mux_1b_2to1
//   WIDTH-generic 2:1 selector for datapath control muxing. The mux path is
//   purely combinational. Alongside it the block keeps:
//     - a registered copy of the mux output,
//     - a saturating count of select changes,
//     - an optional sticky self-check flag.
//
// Optional feature macro: MUX_CHECK_EN
//   defined   : err is set if out ever differs from a separately derived
//               selection on a rising edge; it stays high until reset.
//   undefined : err is tied low and no checker logic is built.
//
// Ports (declaration order is fixed so legacy 4-port positional instances
// of (out, in1, in2, sel) keep working):
//   out     o  WIDTH  combinational result, sel ? in2 : in1
//   in1     i  WIDTH  data selected when sel = 0
//   in2     i  WIDTH  data selected when sel = 1
//   sel     i  1      select
//   clk     i  1      clock, rising edge
//   rst     i  1      asynchronous active-low reset
//   out_q   o  WIDTH  out registered once
//   sel_cnt o  CNT_W  saturating count of sel changes
//   err     o  1      sticky self-check flag (MUX_CHECK_EN only)
// ---------------------------------------------------------------------------
module mux_1b_2to1 #(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned CNT_W = 8
) (
    output logic [WIDTH-1:0] out,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic             sel,
    input  logic             clk,
    input  logic             rst,
    output logic [WIDTH-1:0] out_q,
    output logic [CNT_W-1:0] sel_cnt,
    output logic             err
);

    logic [WIDTH-1:0] out_q_q, out_q_d;
    logic             sel_prev_q, sel_prev_d;
    logic [CNT_W-1:0] sel_cnt_q, sel_cnt_d;

    // Continuous ternary: an unknown sel merges in1/in2, so out stays defined
    // when both data inputs agree. Never depends on clk or rst.
    assign out = sel ? in2 : in1;

    always_comb begin
        out_q_d    = out;
        sel_prev_d = sel;
        sel_cnt_d  = sel_cnt_q;
        // Hold at all-ones instead of wrapping.
        if ((sel != sel_prev_q) && (sel_cnt_q != '1)) begin
            sel_cnt_d = sel_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_q_q    <= '0;
            sel_prev_q <= 1'b0;
            sel_cnt_q  <= '0;
        end else begin
            out_q_q    <= out_q_d;
            sel_prev_q <= sel_prev_d;
            sel_cnt_q  <= sel_cnt_d;
        end
    end

    assign out_q   = out_q_q;
    assign sel_cnt = sel_cnt_q;

`ifdef MUX_CHECK_EN
    logic             err_q, err_d;
    logic [WIDTH-1:0] expected;

    // Built with and/or masking rather than reusing the mux expression, so a
    // fault on the out path is not mirrored into the reference.
    assign expected = (in1 & ~{WIDTH{sel}}) | (in2 & {WIDTH{sel}});

    always_comb begin
        err_d = err_q;
        if (out != expected) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_mux_1b_2to1.sv
// ---------------------------------------------------------------------------
// tb_mux_1b_2to1
//   Self-checking bench for mux_1b_2to1. Two instances share stimulus: the
//   default configuration and one with CNT_W=2 for counter saturation.
//   Inputs change just after a rising edge; expectations are queued at that
//   point and checked at the following falling edge.
// ---------------------------------------------------------------------------
module tb_mux_1b_2to1;

    logic       clk;
    logic       rst;
    logic       in1, in2, sel;
    logic       out, out_q, err;
    logic [7:0] sel_cnt;
    logic       out2, out_q2, err2;
    logic [1:0] sel_cnt2;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    typedef struct {
        logic       out;
        logic       out_q;
        logic [7:0] cnt;
        logic [1:0] cnt2;
        logic       err;
    } exp_t;

    exp_t sb[$];

    // reference state
    logic       m_outq;
    logic       m_prev;
    logic [7:0] m_cnt;
    logic [1:0] m_cnt2;
    logic       m_err;

    mux_1b_2to1 dut (
        .out    (out),
        .in1    (in1),
        .in2    (in2),
        .sel    (sel),
        .clk    (clk),
        .rst    (rst),
        .out_q  (out_q),
        .sel_cnt(sel_cnt),
        .err    (err)
    );

    mux_1b_2to1 #(.WIDTH(1), .CNT_W(2)) dut2 (
        .out    (out2),
        .in1    (in1),
        .in2    (in2),
        .sel    (sel),
        .clk    (clk),
        .rst    (rst),
        .out_q  (out_q2),
        .sel_cnt(sel_cnt2),
        .err    (err2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp_v, $time);
        end
    endtask

    function automatic logic ref_mux(input logic a, input logic b, input logic s);
        return s ? b : a;
    endfunction

    task automatic model_reset();
        m_outq = 1'b0;
        m_prev = 1'b0;
        m_cnt  = '0;
        m_cnt2 = '0;
        m_err  = 1'b0;
    endtask

    // Reference update for one rising edge, using the inputs held across it.
    task automatic model_edge(input logic forced_bad);
        if (rst) begin
            m_outq = forced_bad ? ~ref_mux(in1, in2, sel) : ref_mux(in1, in2, sel);
            if (sel != m_prev) begin
                if (m_cnt  != 8'hFF) m_cnt  = m_cnt + 8'd1;
                if (m_cnt2 != 2'b11) m_cnt2 = m_cnt2 + 2'd1;
            end
            m_prev = sel;
            if (forced_bad) m_err = 1'b1;
        end
    endtask

    task automatic push_exp();
        exp_t e;
        e.out   = ref_mux(in1, in2, sel);
        e.out_q = m_outq;
        e.cnt   = m_cnt;
        e.cnt2  = m_cnt2;
`ifdef MUX_CHECK_EN
        e.err   = m_err;
`else
        e.err   = 1'b0;
`endif
        sb.push_back(e);
    endtask

    task automatic pop_cmp();
        exp_t e;
        if (sb.size() == 0) begin
            chk("sb_empty", 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            chk("out",      out,      e.out);
            chk("out_q",    out_q,    e.out_q);
            chk("sel_cnt",  sel_cnt,  e.cnt);
            chk("err",      err,      e.err);
            chk("out2",     out2,     e.out);
            chk("sel_cnt2", sel_cnt2, e.cnt2);
        end
    endtask

    task automatic cycle(input logic a, input logic b, input logic s);
        @(posedge clk);
        model_edge(1'b0);
        #1;
        in1 = a;
        in2 = b;
        sel = s;
        push_exp();
        @(negedge clk);
        pop_cmp();
    endtask

    // Assert reset between edges, well away from any rising edge.
    task automatic async_reset_assert();
        @(posedge clk);
        model_edge(1'b0);
        #3;
        rst = 1'b0;
        model_reset();
        #1;
    endtask

    initial begin
        rst = 1'b1;
        in1 = 1'b0;
        in2 = 1'b0;
        sel = 1'b0;
        model_reset();
        #1;
        rst = 1'b0;
        #1;
        chk("rst_out_q",   out_q,    0);
        chk("rst_sel_cnt", sel_cnt,  0);
        chk("rst_err",     err,      0);
        chk("rst_cnt2",    sel_cnt2, 0);

        // combinational path works with no clock edge, even in reset
        in1 = 1'b1; in2 = 1'b0; sel = 1'b0;
        #1;
        chk("comb_sel0", out, 1);
        sel = 1'b1;
        #1;
        chk("comb_sel1", out, 0);

        in1 = 1'b0; in2 = 1'b0; sel = 1'b0;
        @(negedge clk);
        rst = 1'b1;

        // three consecutive toggles; first edge counts against sel_prev=0
        cycle(1'b0, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b1);
        cycle(1'b1, 1'b0, 1'b1);
        chk("cnt_three", sel_cnt, 3);
        chk("outq_lag",  out_q,   0);
        // three more toggles: narrow counter saturates
        cycle(1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b1, 1'b1);
        cycle(1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b1, 1'b0);
        chk("cnt_six",   sel_cnt,  6);
        chk("cnt2_sat",  sel_cnt2, 3);

        // random traffic, 320 cycles of 10 time units
        for (int i = 0; i < 320; i++) begin
            cycle(1'($urandom_range(1)), 1'($urandom_range(1)), 1'($urandom_range(1)));
        end

        // build out_q=1, sel_cnt=5 then reset mid-cycle
        async_reset_assert();
        @(negedge clk);
        rst = 1'b1;
        cycle(1'b1, 1'b1, 1'b1);
        cycle(1'b1, 1'b1, 1'b0);
        cycle(1'b1, 1'b1, 1'b1);
        cycle(1'b1, 1'b1, 1'b0);
        cycle(1'b1, 1'b1, 1'b1);
        cycle(1'b1, 1'b1, 1'b1);
        chk("pre_rst_cnt",  sel_cnt, 5);
        chk("pre_rst_outq", out_q,   1);
        async_reset_assert();
        chk("mid_rst_outq", out_q,   0);
        chk("mid_rst_cnt",  sel_cnt, 0);
        chk("mid_rst_err",  err,     0);
        in1 = 1'b0; in2 = 1'b1; sel = 1'b0;
        #1;
        chk("rst_track0", out, 0);
        sel = 1'b1;
        #1;
        chk("rst_track1", out, 1);
        sel = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        cycle(1'b1, 1'b0, 1'b1);
        cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0);

`ifdef MUX_CHECK_EN
        // corrupt out across exactly one rising edge
        @(negedge clk);
        force dut.out = ~ref_mux(in1, in2, sel);
        @(posedge clk);
        model_edge(1'b1);
        #1;
        release dut.out;
        in1 = 1'b1; in2 = 1'b0; sel = 1'b0;
        push_exp();
        @(negedge clk);
        pop_cmp();
        chk("err_set", err, 1);
        cycle(1'b0, 1'b1, 1'b1);
        cycle(1'b1, 1'b1, 1'b0);
        chk("err_sticky", err, 1);
        async_reset_assert();
        chk("err_cleared", err, 0);
        @(negedge clk);
        rst = 1'b1;
        cycle(1'b0, 1'b0, 1'b0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
